// File: rtl/prefetch_unit.sv
// Instruction prefetch stage: sequential fetch over a syn/ack handshake into a
// DEPTH-entry circular queue, with head presentation to the decoder and
// redirect flush that drains any in-flight fetch.
module prefetch_unit #(
  parameter int unsigned          IWIDTH   = 32,
  parameter int unsigned          PC_WIDTH = 32,
  parameter int unsigned          AWIDTH   = 5,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                         pf_clk,
  input  logic                         pf_rst,
  output logic                         pf_o_syn,
  output logic [AWIDTH-1:0]            pf_o_addr_instr,
  input  logic                         pf_i_ack,
  input  logic [IWIDTH-1:0]            pf_i_instr,
  input  logic                         pf_change_pc,
  input  logic [PC_WIDTH-1:0]          pf_alu_pc_value,
  input  logic                         pf_i_stall,
  output logic [IWIDTH-1:0]            pf_o_instr,
  output logic [PC_WIDTH-1:0]          pf_o_pc,
  output logic                         pf_o_ce,
  output logic                         pf_o_stall,
  output logic                         pf_o_flush,
  output logic [$clog2(DEPTH+1)-1:0]   pf_o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  flush_q, flush_d;
  logic [AWIDTH-1:0]     stale_addr_q, stale_addr_d;
  logic [IWIDTH-1:0]     q_instr_q [DEPTH];
  logic [IWIDTH-1:0]     q_instr_d [DEPTH];
  logic [PC_WIDTH-1:0]   q_pc_q    [DEPTH];
  logic [PC_WIDTH-1:0]   q_pc_d    [DEPTH];

  logic                  push_c;
  logic                  pop_c;

  // Pointer advance with wrap at DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state, queue update and redirect handling; redirect overrides push/pop.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    flush_d      = 1'b0;
    stale_addr_d = stale_addr_q;
    q_instr_d    = q_instr_q;
    q_pc_d       = q_pc_q;
    push_c       = (state_q == ST_REQ) && pf_i_ack;
    pop_c        = (count_q != '0) && !pf_i_stall;

    if (pf_change_pc) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = pf_alu_pc_value & ALIGN_MASK;
      flush_d    = 1'b1;
      if ((state_q != ST_IDLE) && !pf_i_ack) begin
        // The memory still owes a response; hold its address until it lands.
        state_d = ST_DRAIN;
        if (state_q == ST_REQ) begin
          stale_addr_d = fetch_pc_q[AWIDTH+1:2];
        end
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      if (push_c) begin
        q_instr_d[wr_ptr_q] = pf_i_instr;
        q_pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d            = ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      unique case (state_q)
        ST_IDLE: begin
          if (count_q < CNT_W'(DEPTH)) begin
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (pf_i_ack) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = (count_d < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (pf_i_ack) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge pf_clk) begin
    if (!pf_rst) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flush_q      <= 1'b0;
      stale_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      flush_q      <= flush_d;
      stale_addr_q <= stale_addr_d;
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge pf_clk) begin
    q_instr_q <= q_instr_d;
    q_pc_q    <= q_pc_d;
  end

  assign pf_o_syn        = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign pf_o_addr_instr = (state_q == ST_DRAIN) ? stale_addr_q : fetch_pc_q[AWIDTH+1:2];
  assign pf_o_instr      = q_instr_q[rd_ptr_q];
  assign pf_o_pc         = q_pc_q[rd_ptr_q];
  assign pf_o_ce         = (count_q != '0);
  assign pf_o_stall      = (count_q == '0);
  assign pf_o_flush      = flush_q;
  assign pf_o_count      = count_q;

endmodule
